// File: rtl/note_prefetch_pkg.sv
// note_prefetch_pkg: music ISA opcodes, REP2 field helpers and fetch FSM states
package note_prefetch_pkg;
   localparam logic [3:0] OP_END = 4'h0;
   localparam logic [3:0] OP_BPM = 4'h1;
   localparam logic [3:0] OP_REP1 = 4'h2;
   localparam logic [3:0] OP_REP2 = 4'h3;
   localparam int NOTE_BIT = 15;
   localparam logic [17:0] START_ADDR_DEF = 18'h0FF00;
   typedef enum logic [1:0] {FETCH, DECODE, STALL, HALT} state_t;
   function automatic logic [5:0] rep_lo(input logic [15:0] w);
      return w[11:6];
   endfunction
   function automatic logic [2:0] rep_cnt(input logic [15:0] w);
      return w[5:3];
   endfunction
   function automatic logic [2:0] rep_lvl(input logic [15:0] w);
      return w[2:0];
   endfunction
endpackage

// File: rtl/note_prefetch_if.sv
// note_prefetch_if: instruction stream valid/ready handshake towards the execute stage
interface note_prefetch_if;
   logic [15:0] INS;
   logic INS_VALID;
   logic INS_READY;
   modport master(output INS, INS_VALID, input INS_READY);
   modport slave(input INS, INS_VALID, output INS_READY);
endinterface

// File: rtl/note_prefetch_ins_fifo.sv
// ins_fifo: synchronous first-word-fall-through FIFO; push while full is taken only alongside a pop
module ins_fifo #(
   parameter int W = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign empty = cnt == '0;
   assign full = cnt == (AW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || pop);
   assign dout = mem[rd];
   // storage write, no reset needed since reads are gated by empty
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk)
      if (rst) begin
         wr <= '0;
         rd <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wr <= wr + AW'(1);
         if (do_pop) rd <= rd + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/note_prefetch.sv
// note_prefetch: fetches music words from SRAM, resolves REP1/REP2 loops and streams the rest through a FIFO
module note_prefetch
   import note_prefetch_pkg::*;
#(
   parameter logic [17:0] START_ADDR = START_ADDR_DEF,
   parameter int SRAM_WAIT = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [17:0] SRAM_A,
   input  logic [15:0] SRAM_D,
   note_prefetch_if.master bus,
   output logic        HALTED,
   output logic        ERR
);
   localparam logic [2:0] WAIT_END = 3'(SRAM_WAIT);
   state_t state, state_n;
   logic [17:0] pc, pc_n;
   logic [2:0] wcnt;
   logic [15:0] word, head;
   logic [11:0] rep_hi;
   logic [2:0] ctr [8];
   logic [3:0] op;
   logic [2:0] lvl;
   logic push, pop, space, full, empty, err_set;
   logic is_note, is_end, is_out, is_rep1, is_rep2, decode;
   assign op = word[15:12];
   assign lvl = rep_lvl(word);
   assign is_note = word[NOTE_BIT];
   assign is_end = !is_note && op == OP_END;
   assign is_out = is_note || is_end || op == OP_BPM;
   assign is_rep1 = !is_note && op == OP_REP1;
   assign is_rep2 = !is_note && op == OP_REP2;
   assign decode = state == DECODE || state == STALL;
   assign pop = !empty && bus.INS_READY;
   assign space = !full || pop;
   assign SRAM_A = pc;
   assign bus.INS = empty ? 16'h0000 : head;
   assign bus.INS_VALID = !empty;
   assign HALTED = state == HALT;
   ins_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(CLK),
      .rst(RST),
      .push(push),
      .pop(pop),
      .din(word),
      .dout(head),
      .full(full),
      .empty(empty)
   );
   // next state, next pc and push decision; repeats are consumed here and never pushed
   always_comb begin
      state_n = state;
      pc_n = pc;
      push = 1'b0;
      err_set = 1'b0;
      if (state == FETCH) state_n = wcnt == WAIT_END ? DECODE : FETCH;
      else if (decode) begin
         if (is_out) begin
            push = space;
            state_n = !space ? STALL : is_end ? HALT : FETCH;
            pc_n = space && !is_end ? pc + 18'd1 : pc;
         end else if (is_rep1) begin
            pc_n = pc + 18'd1;
            state_n = FETCH;
         end else if (is_rep2) begin
            pc_n = ctr[lvl] == 3'd1 ? pc + 18'd1 : {rep_hi, rep_lo(word)};
            state_n = FETCH;
         end else begin
            err_set = 1'b1;
            state_n = HALT;
         end
      end
   end
   // FSM state, program counter and sticky error flag
   always_ff @(posedge CLK)
      if (RST) begin
         state <= FETCH;
         pc <= START_ADDR;
         ERR <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         ERR <= ERR | err_set;
      end
   // wait counter, fetched word, repeat high bits and loop counters
   always_ff @(posedge CLK)
      if (RST) begin
         wcnt <= 3'd0;
         word <= 16'h0000;
         rep_hi <= 12'h000;
         for (int i = 0; i < 8; i++) ctr[i] <= 3'd0;
      end else begin
         wcnt <= state == FETCH && wcnt != WAIT_END ? wcnt + 3'd1 : 3'd0;
         if (state == FETCH && wcnt == WAIT_END) word <= SRAM_D;
         if (state == DECODE && is_rep1) rep_hi <= word[11:0];
         if (state == DECODE && is_rep2) ctr[lvl] <= ctr[lvl] == 3'd0 ? rep_cnt(word) : ctr[lvl] - 3'd1;
      end
endmodule
